// File: rtl/fle_ccff_pkg.sv
// Shared types and constants for the fle configuration-chain loader.
// The readback-verify feature is enabled by defining FLE_CCFF_VERIFY_EN.
package fle_ccff_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } ccff_state_e;

  localparam logic [7:0] CRC8_POLY     = 8'h07;
  localparam int         DEF_CHAIN_LEN = 20;
  localparam int         DEF_WORD_W    = 8;

  // One serial CRC-8 step: shift left, fold in the polynomial on feedback.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    logic fb;
    fb = crc[7] ^ bit_in;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/fle_ccff_crc8.sv
// Serial CRC-8 accumulator (poly 0x07, init 0x00) with clear and enable.
// crc_nxt exposes the value after absorbing bit_in this cycle.
module fle_ccff_crc8
  import fle_ccff_pkg::*;
(
  input  logic       prog_clk,
  input  logic       pReset,
  input  logic       clear,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc,
  output logic [7:0] crc_nxt
);

  logic [7:0] crc_r;

  assign crc_nxt = crc8_step(crc_r, bit_in);
  assign crc     = crc_r;

  // Accumulate one bit per enabled cycle; clear wins over enable.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      crc_r <= 8'h00;
    end else if (clear) begin
      crc_r <= 8'h00;
    end else if (en) begin
      crc_r <= crc_nxt;
    end else begin
      crc_r <= crc_r;
    end
  end

endmodule

// File: rtl/fle_ccff_loader.sv
// Configuration-chain loader for an fle tile (or daisy chain of tiles).
// Takes words over valid/ready, shifts them LSB first into ccff_head one
// bit per prog_clk, and pulses done when CHAIN_LEN bits are in place.
// Define FLE_CCFF_VERIFY_EN to add a recirculating readback with CRC-8 compare.
module fle_ccff_loader
  import fle_ccff_pkg::*;
#(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int WORD_W    = DEF_WORD_W
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic              ccff_tail,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  output logic              config_enable,
  output logic              busy,
  output logic              done,
  output logic              verify_err
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CHAIN_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  ccff_state_e       state_r;
  logic [WORD_W-1:0] buf_r;
  logic              buf_valid_r;
  logic [IDX_W-1:0]  widx_r;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic              head_r;
  logic              shift_en_r;
  logic              cfg_en_r;
  logic              busy_r;
  logic              done_r;
  logic              verr_r;

  logic              room_s;
  logic              ready_s;
  logic              take_s;
  logic              issue_s;
  logic              issue_bit_s;

  // Handshake and next-bit selection; an empty buffer forwards cfg_data[0]
  // directly so the first bit of a freshly accepted word is not delayed.
  always_comb begin
    room_s      = (bit_cnt_r < FULL_CNT);
    ready_s     = 1'b0;
    issue_bit_s = 1'b0;
    if (state_r == ST_LOAD) begin
      if (!buf_valid_r) begin
        ready_s = room_s;
      end else if ((widx_r == LAST_IDX) && (bit_cnt_r < LAST_CNT)) begin
        ready_s = 1'b1;
      end else begin
        ready_s = 1'b0;
      end
    end else begin
      ready_s = 1'b0;
    end
    take_s  = ready_s & cfg_valid;
    issue_s = (state_r == ST_LOAD) && room_s && (buf_valid_r || take_s);
    if (buf_valid_r) begin
      issue_bit_s = buf_r[widx_r];
    end else begin
      issue_bit_s = cfg_data[0];
    end
  end

  assign cfg_ready     = ready_s;
  assign ccff_shift_en = shift_en_r;
  assign config_enable = cfg_en_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign verify_err    = verr_r;

`ifdef FLE_CCFF_VERIFY_EN
  logic       crc_clear_s;
  logic [7:0] crc_load_s;
  logic [7:0] crc_load_nxt_s;
  logic [7:0] crc_tail_s;
  logic [7:0] crc_tail_nxt_s;

  assign crc_clear_s = (state_r == ST_IDLE) && start && !abort;
  // During readback the chain recirculates through the loader.
  assign ccff_head   = (state_r == ST_VERIFY) ? ccff_tail : head_r;

  fle_ccff_crc8 u_crc_load (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .clear    (crc_clear_s),
    .en       (issue_s),
    .bit_in   (issue_bit_s),
    .crc      (crc_load_s),
    .crc_nxt  (crc_load_nxt_s)
  );

  fle_ccff_crc8 u_crc_tail (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .clear    (crc_clear_s),
    .en       (state_r == ST_VERIFY),
    .bit_in   (ccff_tail),
    .crc      (crc_tail_s),
    .crc_nxt  (crc_tail_nxt_s)
  );

  logic [7:0] unused_crc_s;
  assign unused_crc_s = crc_load_nxt_s ^ crc_tail_s;
`else
  logic unused_tail_s;
  assign unused_tail_s = ccff_tail;
  assign ccff_head     = head_r;
`endif

  // Loader FSM, word buffer and all registered chain-side outputs.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_r     <= ST_IDLE;
      buf_r       <= '0;
      buf_valid_r <= 1'b0;
      widx_r      <= '0;
      bit_cnt_r   <= '0;
      head_r      <= 1'b0;
      shift_en_r  <= 1'b0;
      cfg_en_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      verr_r      <= 1'b0;
    end else if (abort) begin
      state_r     <= ST_IDLE;
      buf_valid_r <= 1'b0;
      widx_r      <= '0;
      bit_cnt_r   <= '0;
      head_r      <= 1'b0;
      shift_en_r  <= 1'b0;
      cfg_en_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      verr_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      verr_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r     <= ST_LOAD;
            cfg_en_r    <= 1'b1;
            busy_r      <= 1'b1;
            bit_cnt_r   <= '0;
            buf_valid_r <= 1'b0;
            widx_r      <= '0;
          end
        end
        ST_LOAD: begin
          if (!room_s) begin
            // Last chain bit is on the wire now; drop any leftover word bits.
            buf_valid_r <= 1'b0;
            widx_r      <= '0;
`ifdef FLE_CCFF_VERIFY_EN
            state_r     <= ST_VERIFY;
            shift_en_r  <= 1'b1;
            bit_cnt_r   <= '0;
`else
            state_r     <= ST_DONE;
            shift_en_r  <= 1'b0;
            cfg_en_r    <= 1'b0;
            done_r      <= 1'b1;
`endif
          end else if (issue_s) begin
            head_r     <= issue_bit_s;
            shift_en_r <= 1'b1;
            bit_cnt_r  <= bit_cnt_r + CNT_W'(1);
            if (buf_valid_r) begin
              if (widx_r == LAST_IDX) begin
                widx_r <= '0;
                if (take_s) begin
                  buf_r <= cfg_data;
                end else begin
                  buf_valid_r <= 1'b0;
                end
              end else begin
                widx_r <= widx_r + IDX_W'(1);
              end
            end else begin
              buf_r <= cfg_data;
              if (WORD_W > 1) begin
                widx_r      <= IDX_W'(1);
                buf_valid_r <= 1'b1;
              end else begin
                widx_r      <= '0;
                buf_valid_r <= 1'b0;
              end
            end
          end else begin
            // Host stall: chain is left untouched, head holds.
            shift_en_r <= 1'b0;
          end
        end
        ST_VERIFY: begin
`ifdef FLE_CCFF_VERIFY_EN
          bit_cnt_r <= bit_cnt_r + CNT_W'(1);
          if (bit_cnt_r == LAST_CNT) begin
            state_r    <= ST_DONE;
            shift_en_r <= 1'b0;
            cfg_en_r   <= 1'b0;
            done_r     <= 1'b1;
            verr_r     <= (crc_tail_nxt_s != crc_load_s);
          end
`else
          state_r    <= ST_IDLE;
          shift_en_r <= 1'b0;
          cfg_en_r   <= 1'b0;
          busy_r     <= 1'b0;
`endif
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          shift_en_r <= 1'b0;
          cfg_en_r   <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fle_ccff_loader.sv
// Self-checking bench for fle_ccff_loader (CHAIN_LEN=20, WORD_W=8).
// Expected head bits are queued at each handshake and popped on every
// load shift; a 20-stage chain model sits on ccff_head/ccff_tail.
module tb_fle_ccff_loader;

  localparam int CL = 20;
`ifdef FLE_CCFF_VERIFY_EN
  localparam int VOFF = CL;
`else
  localparam int VOFF = 0;
`endif

  logic          prog_clk = 1'b0;
  logic          pReset;
  logic          start;
  logic          abort;
  logic [7:0]    cfg_data;
  logic          cfg_valid;
  logic          cfg_ready;
  logic          ccff_tail;
  logic          ccff_head;
  logic          ccff_shift_en;
  logic          config_enable;
  logic          busy;
  logic          done;
  logic          verify_err;

  logic [CL-1:0] chain;
  logic          stuck7;
  logic          exp_q[$];
  int            total = 0;
  int            bad = 0;

  assign ccff_tail = chain[CL-1];

  always #5 prog_clk = ~prog_clk;

  fle_ccff_loader #(.CHAIN_LEN(CL), .WORD_W(8)) dut (
    .prog_clk      (prog_clk),
    .pReset        (pReset),
    .start         (start),
    .abort         (abort),
    .cfg_data      (cfg_data),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .ccff_tail     (ccff_tail),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .config_enable (config_enable),
    .busy          (busy),
    .done          (done),
    .verify_err    (verify_err)
  );

  typedef struct {
    logic [23:0] words;        // {w2, w1, w0}
    int          stall_from;
    int          stall_len;
    int          exp_last_shift;
    int          exp_done;
    int          exp_hs;
    logic [19:0] exp_chain;    // chain[19] (tail side) is the MSB
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic b);
    logic [7:0] n;
    n = {c[6:0], 1'b0};
    if (c[7] ^ b) n = n ^ 8'h07;
    return n;
  endfunction

  task automatic run_load(input logic [23:0] words, input int stall_from, input int stall_len,
                          input int abort_at, output int done_cyc, output int first_sh,
                          output int last_sh, output int n_sh, output int hs,
                          output logic verr_act, output logic verr_exp);
    int         wi;
    int         pushed;
    logic       prev_head;
    logic       exp_bit;
    logic [7:0] crc_l;
    logic [7:0] crc_t;
    logic [7:0] w;
    bit         stop;
    wi = 0; pushed = 0; stop = 0; crc_l = 8'h00; crc_t = 8'h00;
    done_cyc = -1; first_sh = -1; last_sh = -1; n_sh = 0; hs = 0;
    verr_act = 1'b0; verr_exp = 1'b0;
    exp_q.delete();
    chain = '0;
    @(negedge prog_clk);
    start = 1'b1;
    cfg_valid = 1'b0;
    prev_head = ccff_head;
    for (int cyc = 1; cyc < 200 && !stop; cyc++) begin
      @(negedge prog_clk);
      start = 1'b0;
      if (abort) begin
        abort = 1'b0;
        cfg_valid = 1'b0;
        stop = 1;
      end else begin
        if (ccff_shift_en) begin
          n_sh++;
          if (first_sh < 0) first_sh = cyc;
          last_sh = cyc;
          if (n_sh <= CL) begin
            if (exp_q.size() == 0) begin
              check("sb_underflow", 32'd1, 32'd0);
            end else begin
              exp_bit = exp_q.pop_front();
              check("head_bit", {31'd0, ccff_head}, {31'd0, exp_bit});
              crc_l = crc8(crc_l, exp_bit);
            end
          end else begin
            check("verify_recirc", {31'd0, ccff_head}, {31'd0, chain[CL-1]});
            crc_t = crc8(crc_t, chain[CL-1]);
          end
          chain = {chain[CL-2:0], ccff_head};
          if (stuck7) chain[7] = 1'b0;
        end else if (config_enable && n_sh > 0 && n_sh < CL) begin
          check("head_hold", {31'd0, ccff_head}, {31'd0, prev_head});
        end
        prev_head = ccff_head;
        if (done) begin
          done_cyc = cyc;
          verr_act = verify_err;
          cfg_valid = 1'b0;
          stop = 1;
        end else begin
          if (cyc == abort_at) abort = 1'b1;
          cfg_valid = (wi < 3) && !(cyc >= stall_from && cyc < stall_from + stall_len);
          w = 8'h00;
          if (wi < 3) w = words[wi*8 +: 8];
          cfg_data = w;
          if (cfg_ready && cfg_valid) begin
            hs++;
            for (int b = 0; b < 8; b++) begin
              if (pushed < CL) begin
                exp_q.push_back(w[b]);
                pushed++;
              end
            end
            wi++;
          end
        end
      end
    end
`ifdef FLE_CCFF_VERIFY_EN
    verr_exp = (crc_l != crc_t);
`else
    verr_exp = 1'b0;
`endif
  endtask

  initial begin
    int   dc, fs, ls, ns, hs;
    logic va, ve;

    vecs[0] = '{24'hFF3CA5, 0, 0, 21, 22, 3, 20'hA53CF};
    vecs[1] = '{24'h0F8001, 0, 0, 21, 22, 3, 20'h8001F};
    vecs[2] = '{24'hFF3CA5, 8, 6, 26, 27, 3, 20'hA53CF};
    vecs[3] = '{24'h5AFF00, 0, 0, 21, 22, 3, 20'h00FF5};

    // Reset with start and cfg_valid asserted: everything stays quiet.
    pReset = 1'b1; start = 1'b1; abort = 1'b0; cfg_valid = 1'b1; cfg_data = 8'hFF;
    stuck7 = 1'b0; chain = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge prog_clk);
      check("reset_outputs",
            {25'd0, cfg_ready, ccff_head, ccff_shift_en, config_enable, busy, done, verify_err},
            32'd0);
    end
    pReset = 1'b0; start = 1'b0; cfg_valid = 1'b0;
    @(negedge prog_clk);
    check("idle_after_reset", {30'd0, busy, config_enable}, 32'd0);

    // Table-driven loads.
    for (int v = 0; v < 4; v++) begin
      run_load(vecs[v].words, vecs[v].stall_from, vecs[v].stall_len, -1,
               dc, fs, ls, ns, hs, va, ve);
      check("done_cycle", dc, vecs[v].exp_done + VOFF);
      check("first_shift", fs, 32'd2);
      check("last_shift", ls, vecs[v].exp_last_shift + VOFF);
      check("shift_count", ns, CL + VOFF);
      check("handshakes", hs, vecs[v].exp_hs);
      check("chain_contents", {12'd0, chain}, {12'd0, vecs[v].exp_chain});
      check("verify_err", {31'd0, va}, {31'd0, ve});
      @(negedge prog_clk);
      check("done_one_cycle", {30'd0, done, busy}, 32'd0);
    end

    // Abort while the 10th bit is shifting.
    run_load(24'hFF3CA5, 0, 0, 11, dc, fs, ls, ns, hs, va, ve);
    check("abort_outputs",
          {26'd0, busy, ccff_shift_en, config_enable, cfg_ready, done, verify_err}, 32'd0);
    check("abort_bits_shifted", ns, 32'd10);
    for (int i = 0; i < 5; i++) begin
      @(negedge prog_clk);
      check("abort_no_done", {30'd0, done, busy}, 32'd0);
    end
    run_load(24'hFF3CA5, 0, 0, -1, dc, fs, ls, ns, hs, va, ve);
    check("reload_done_cycle", dc, 32'd22 + VOFF);
    check("reload_chain", {12'd0, chain}, 32'h000A53CF);

`ifdef FLE_CCFF_VERIFY_EN
    // Stage 7 stuck at zero corrupts readback.
    stuck7 = 1'b1;
    run_load(24'hFF3CA5, 0, 0, -1, dc, fs, ls, ns, hs, va, ve);
    stuck7 = 1'b0;
    check("stuck_done_cycle", dc, 32'd42);
    check("stuck_verify_err", {31'd0, va}, {31'd0, ve});
    check("stuck_detected", {31'd0, va}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
